// File: rtl/rl_lj_pair_scheduler.sv
// rl_lj_pair_scheduler: walks (i,j) particle pairs in row-major order
// for the LJ force pipeline, with back-pressure stalls and a drain phase.
module rl_lj_pair_scheduler #(
    parameter int ADDR_WIDTH   = 7,
    parameter int ID_WIDTH     = 20,
    parameter int NUM_FILTER   = 4,
    parameter int DRAIN_CYCLES = 31
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH:0]     cfg_ref_num,
    input  logic [ADDR_WIDTH:0]     cfg_nbr_num,
    input  logic [1:0]              cfg_mode,
    input  logic [NUM_FILTER-1:0]   back_pressure,
    output logic [ADDR_WIDTH-1:0]   home_rdaddr,
    output logic [ADDR_WIDTH-1:0]   neighbor_rdaddr,
    output logic                    rden,
    output logic                    input_valid,
    output logic [ID_WIDTH-1:0]     ref_particle_id,
    output logic [ID_WIDTH-1:0]     neighbor_particle_id,
    output logic [2*ADDR_WIDTH+1:0] pair_count,
    output logic                    busy,
    output logic                    done
);

    localparam int AW = ADDR_WIDTH + 1;
    localparam int PW = 2 * ADDR_WIDTH + 2;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         r_q, r_d;
    logic [AW-1:0]         n_q, n_d;
    logic [AW-1:0]         i_q, i_d;
    logic [AW-1:0]         j_q, j_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] ha_q, ha_d;
    logic [ADDR_WIDTH-1:0] na_q, na_d;
    logic                  rden_q, rden_d;
    logic                  iv_q;
    logic [ID_WIDTH-1:0]   rid_q, nid_q;
    logic [PW-1:0]         pc_q, pc_d;
    logic [DW-1:0]         dc_q, dc_d;

    logic                  bp_any;
    logic                  f_ok;
    logic [AW-1:0]         f_i, f_j;
    logic                  half, excl;
    logic [AW-1:0]         jn1, jn, in1, rj;
    logic                  same_ok, row_ok;

    assign bp_any = |back_pressure;

    // First legal pair, taken from the live configuration at start.
    always_comb begin
        f_ok = 1'b0;
        f_i  = '0;
        f_j  = '0;
        if (cfg_mode[1]) begin
            f_ok = (cfg_ref_num != '0) && (cfg_nbr_num > AW'(1));
            f_j  = AW'(1);
        end else if (cfg_mode[0]) begin
            if ((cfg_ref_num != '0) && (cfg_nbr_num > AW'(1))) begin
                f_ok = 1'b1;
                f_j  = AW'(1);
            end else if ((cfg_nbr_num == AW'(1)) &&
                         (cfg_ref_num > AW'(1))) begin
                f_ok = 1'b1;
                f_i  = AW'(1);
            end
        end else begin
            f_ok = (cfg_ref_num != '0) && (cfg_nbr_num != '0);
        end
    end

    assign half = mode_q[1];
    assign excl = (mode_q == 2'b01);

    // Successor of (i_q,j_q); only row 0 can lack a legal j in mode 01,
    // and in half-shell an empty row means every later row is empty too.
    assign jn1     = j_q + AW'(1);
    assign jn      = (excl && (jn1 == i_q)) ? j_q + AW'(2) : jn1;
    assign in1     = i_q + AW'(1);
    assign rj      = half ? in1 + AW'(1) : '0;
    assign same_ok = (jn < n_q);
    assign row_ok  = (in1 < r_q) && (rj < n_q);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        n_d     = n_q;
        mode_d  = mode_q;
        i_d     = i_q;
        j_d     = j_q;
        ha_d    = ha_q;
        na_d    = na_q;
        rden_d  = 1'b0;
        pc_d    = pc_q;
        dc_d    = dc_q;
        if (abort) begin
            if (state_q != IDLE) begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        r_d    = cfg_ref_num;
                        n_d    = cfg_nbr_num;
                        mode_d = cfg_mode;
                        pc_d   = '0;
                        dc_d   = '0;
                        i_d    = f_i;
                        j_d    = f_j;
                        state_d = f_ok ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    if (!bp_any) begin
                        rden_d = 1'b1;
                        ha_d   = i_q[ADDR_WIDTH-1:0];
                        na_d   = j_q[ADDR_WIDTH-1:0];
                        pc_d   = pc_q + PW'(1);
                        if (same_ok) begin
                            j_d = jn;
                        end else if (row_ok) begin
                            i_d = in1;
                            j_d = rj;
                        end else begin
                            dc_d    = '0;
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bp_any) begin
                        dc_d = '0;
                    end else if (dc_q == DLAST) begin
                        state_d = DONE;
                    end else begin
                        dc_d = dc_q + DW'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            n_q     <= '0;
            mode_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ha_q    <= '0;
            na_q    <= '0;
            rden_q  <= 1'b0;
            iv_q    <= 1'b0;
            rid_q   <= '0;
            nid_q   <= '0;
            pc_q    <= '0;
            dc_q    <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            i_q     <= i_d;
            j_q     <= j_d;
            ha_q    <= ha_d;
            na_q    <= na_d;
            rden_q  <= rden_d;
            iv_q    <= rden_q;
            rid_q   <= ID_WIDTH'(ha_q);
            nid_q   <= ID_WIDTH'(na_q);
            pc_q    <= pc_d;
            dc_q    <= dc_d;
        end
    end

    assign home_rdaddr          = ha_q;
    assign neighbor_rdaddr      = na_q;
    assign rden                 = rden_q;
    assign input_valid          = iv_q;
    assign ref_particle_id      = rid_q;
    assign neighbor_particle_id = nid_q;
    assign pair_count           = pc_q;
    assign busy                 = (state_q != IDLE);
    assign done                 = (state_q == DONE);

endmodule

// File: tb/tb_rl_lj_pair_scheduler.sv
// Scoreboard bench for rl_lj_pair_scheduler: directed runs push the
// hand-listed pair sequence; a monitor pops on rden and input_valid.
module tb_rl_lj_pair_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_ref_num;
    logic [7:0]  cfg_nbr_num;
    logic [1:0]  cfg_mode;
    logic [3:0]  back_pressure;
    logic [6:0]  home_rdaddr;
    logic [6:0]  neighbor_rdaddr;
    logic        rden;
    logic        input_valid;
    logic [19:0] ref_particle_id;
    logic [19:0] neighbor_particle_id;
    logic [15:0] pair_count;
    logic        busy;
    logic        done;

    int n_pass;
    int n_tot;
    int eq_i[$];
    int eq_j[$];
    int iq_i[$];
    int iq_j[$];

    rl_lj_pair_scheduler dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .abort                (abort),
        .cfg_ref_num          (cfg_ref_num),
        .cfg_nbr_num          (cfg_nbr_num),
        .cfg_mode             (cfg_mode),
        .back_pressure        (back_pressure),
        .home_rdaddr          (home_rdaddr),
        .neighbor_rdaddr      (neighbor_rdaddr),
        .rden                 (rden),
        .input_valid          (input_valid),
        .ref_particle_id      (ref_particle_id),
        .neighbor_particle_id (neighbor_particle_id),
        .pair_count           (pair_count),
        .busy                 (busy),
        .done                 (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act,
                                input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    task automatic push(input int i, input int j);
        eq_i.push_back(i);
        eq_j.push_back(j);
    endtask

    // Monitor: compares issued addresses and delayed IDs with the queues.
    initial begin
        int a;
        int b;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (input_valid) begin
                    if (iq_i.size() == 0) begin
                        n_tot++;
                        $display("FAIL id_unexpected: got ref=%0d nbr=%0d",
                                 ref_particle_id, neighbor_particle_id);
                    end else begin
                        a = iq_i.pop_front();
                        b = iq_j.pop_front();
                        chk("ref_id", int'(ref_particle_id), a);
                        chk("nbr_id", int'(neighbor_particle_id), b);
                    end
                end
                if (rden) begin
                    if (eq_i.size() == 0) begin
                        n_tot++;
                        $display("FAIL rden_unexpected: got (%0d,%0d) none expected",
                                 home_rdaddr, neighbor_rdaddr);
                    end else begin
                        a = eq_i.pop_front();
                        b = eq_j.pop_front();
                        chk("home_addr", int'(home_rdaddr), a);
                        chk("nbr_addr", int'(neighbor_rdaddr), b);
                        iq_i.push_back(a);
                        iq_j.push_back(b);
                    end
                end
            end
        end
    end

    task automatic run(input string nm, input int r, input int n,
                       input int md, input int npairs, input int span,
                       input int dly, input int bp1, input int bp2,
                       input int ab, input int rs, input int pc,
                       input int budget);
        int first;
        int last;
        int cnt;
        int dcyc;
        int dn;
        first = -1;
        last  = -1;
        cnt   = 0;
        dcyc  = -1;
        dn    = 0;
        @(negedge clk);
        #1;
        cfg_ref_num = 8'(r);
        cfg_nbr_num = 8'(n);
        cfg_mode    = 2'(md);
        start       = 1'b1;
        @(negedge clk);
        #1;
        start       = 1'b0;
        cfg_ref_num = 8'd5;
        cfg_nbr_num = 8'd7;
        cfg_mode    = ~cfg_mode;
        for (int c = 0; c < budget; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (rden) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
            if (done) begin
                dn++;
                if (dcyc < 0) dcyc = c;
            end
            if (c == 1 && npairs > 0) chk({nm, ".busy_run"}, int'(busy), 1);
            if ((ab >= 0 && c == ab + 1) || (rs >= 0 && c == rs + 1)) begin
                chk({nm, ".rden_after_stop"}, int'(rden), 0);
                chk({nm, ".busy_after_stop"}, int'(busy), 0);
            end
            if (rs >= 0 && c == rs + 1)
                chk({nm, ".pc_in_reset"}, int'(pair_count), 0);
            if (rs >= 0 && c == rs + 2) rst = 1'b1;
            if ((bp1 >= 0 && c >= bp1 && c < bp1 + 3) ||
                (bp2 >= 0 && c >= bp2 && c < bp2 + 3))
                back_pressure = 4'b0010;
            else
                back_pressure = 4'b0000;
            abort = (ab >= 0 && c == ab);
            if (rs >= 0 && c == rs) begin
                rst = 1'b0;
                iq_i.delete();
                iq_j.delete();
            end
            start = (npairs >= 3 && c == 2);
            if (dcyc >= 0 && c >= dcyc + 2) break;
        end
        start         = 1'b0;
        abort         = 1'b0;
        back_pressure = 4'b0000;
        chk({nm, ".rden_cycles"}, cnt, npairs);
        if (span >= 0) chk({nm, ".issue_span"}, last - first, span);
        if (dly >= 0) chk({nm, ".drain_delay"}, dcyc - last, dly);
        chk({nm, ".done_pulses"}, dn, (ab < 0 && rs < 0) ? 1 : 0);
        chk({nm, ".pair_count"}, int'(pair_count), pc);
        chk({nm, ".busy_end"}, int'(busy), 0);
        chk({nm, ".queue_left"}, eq_i.size(), 0);
        eq_i.delete();
        eq_j.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass        = 0;
        n_tot         = 0;
        rst           = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        back_pressure = 4'b0000;
        cfg_ref_num   = 8'd0;
        cfg_nbr_num   = 8'd0;
        cfg_mode      = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk("reset.rden", int'(rden), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.pair_count", int'(pair_count), 0);
        chk("reset.home_addr", int'(home_rdaddr), 0);
        chk("reset.input_valid", int'(input_valid), 0);
        chk("reset.ref_id", int'(ref_particle_id), 0);
        rst = 1'b1;
        @(negedge clk);

        push(0, 0); push(0, 1); push(0, 2);
        push(1, 0); push(1, 1); push(1, 2);
        push(2, 0); push(2, 1); push(2, 2);
        run("m00_3x3", 3, 3, 0, 9, 8, 31, -1, -1, -1, -1, 9, 80);

        push(0, 1); push(0, 2); push(1, 0);
        push(1, 2); push(2, 0); push(2, 1);
        run("m01_3x3", 3, 3, 1, 6, 5, 31, -1, -1, -1, -1, 6, 80);

        push(0, 1); push(0, 2); push(0, 3);
        push(1, 2); push(1, 3); push(2, 3);
        run("hs11_4x4", 4, 4, 3, 6, 5, 31, -1, -1, -1, -1, 6, 80);

        run("hs10_1x1", 1, 1, 2, 0, -1, -1, -1, -1, -1, -1, 0, 20);
        run("m01_1x1", 1, 1, 1, 0, -1, -1, -1, -1, -1, -1, 0, 20);
        run("m00_r0", 0, 5, 0, 0, -1, -1, -1, -1, -1, -1, 0, 20);

        push(1, 0);
        run("m01_2x1", 2, 1, 1, 1, 0, 31, -1, -1, -1, -1, 1, 60);

        push(0, 1); push(0, 2); push(1, 2);
        run("hs10_128x3", 128, 3, 2, 3, 2, 31, -1, -1, -1, -1, 3, 60);

        push(0, 0); push(0, 1); push(0, 2);
        push(1, 0); push(1, 1); push(1, 2);
        push(2, 0); push(2, 1); push(2, 2);
        run("m00_bp", 3, 3, 0, 9, 11, 43, 4, 21, -1, -1, 9, 100);

        push(0, 0); push(0, 1); push(0, 2);
        push(1, 0); push(1, 1);
        run("m00_abort", 3, 3, 0, 5, -1, -1, -1, -1, 5, -1, 5, 60);

        push(0, 0); push(0, 1); push(0, 2);
        push(1, 0); push(1, 1); push(1, 2);
        push(2, 0); push(2, 1); push(2, 2);
        run("m00_rerun1", 3, 3, 0, 9, 8, 31, -1, -1, -1, -1, 9, 80);

        push(0, 0); push(0, 1); push(0, 2);
        push(1, 0); push(1, 1);
        run("m00_rst", 3, 3, 0, 5, -1, -1, -1, -1, -1, 5, 0, 60);

        push(0, 0); push(0, 1); push(0, 2);
        push(1, 0); push(1, 1); push(1, 2);
        push(2, 0); push(2, 1); push(2, 2);
        run("m00_rerun2", 3, 3, 0, 9, 8, 31, -1, -1, -1, -1, 9, 80);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
